// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline stage register with valid/ready handshake,
// optional two-entry skid buffer, controller hold (stall) and flush (squash to NOP).
// Ports:
//   clk, rst                  clock; asynchronous active-low reset
//   hold_i, flush_i           stall (freeze all state) / squash (empty the stage)
//   in_valid_i, in_ready_o,   upstream handshake and payload
//   in_data_i
//   out_valid_o, out_ready_i, downstream handshake and payload (NOP_VAL when invalid)
//   out_data_o
//   count_o                   occupied entries: 0, 1 or 2
module pipe_stage_reg #(
  parameter int             DW      = 64,
  parameter logic [DW-1:0]  NOP_VAL = {DW{1'b0}},
  parameter bit             SKID_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold_i,
  input  logic          flush_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o,
  output logic [1:0]    count_o
);
  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;
  state_t        state_q, state_d;
  logic [DW-1:0] main_q, main_d, skid_q, skid_d;
  logic [1:0]    count_q, count_d;
  logic          in_fire, out_fire;
  // With the skid buffer the upstream ready depends only on registered state;
  // without it, a full stage can accept only when the downstream drains it this cycle.
  assign in_ready_o  = !hold_i && !flush_i &&
                       (SKID_EN ? (state_q != SKID) : (state_q == EMPTY || out_ready_i));
  assign out_valid_o = state_q != EMPTY;
  assign out_data_o  = main_q;
  assign count_o     = count_q;
  assign in_fire     = in_valid_i && in_ready_o;
  assign out_fire    = out_valid_o && out_ready_i && !hold_i;
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = EMPTY;
      main_d  = NOP_VAL;
      skid_d  = NOP_VAL;
    end else begin
      case (state_q)
        EMPTY: if (in_fire) begin
          state_d = FULL;
          main_d  = in_data_i;
        end
        FULL: begin
          if (in_fire && out_fire) main_d = in_data_i;
          else if (in_fire && SKID_EN) begin
            state_d = SKID;
            skid_d  = in_data_i;
          end else if (out_fire) begin
            state_d = EMPTY;
            main_d  = NOP_VAL;
          end
        end
        SKID: if (out_fire) begin
          state_d = FULL;
          main_d  = skid_q;
          skid_d  = NOP_VAL;
        end
        default: begin
          state_d = EMPTY;
          main_d  = NOP_VAL;
          skid_d  = NOP_VAL;
        end
      endcase
    end
    count_d = (state_d == SKID) ? 2'd2 : (state_d == FULL) ? 2'd1 : 2'd0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      main_q  <= NOP_VAL;
      skid_q  <= NOP_VAL;
      count_q <= 2'd0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      count_q <= count_d;
    end
  end
endmodule
